led_pattern_checker: RTL and testbench

Monitors the rotating one-hot LED bus driven by the shift-register path and checks it. Verifies that every change is a single-position rotation and that changes arrive at a constant interval. Reports lock status, the measured step period, and sticky error information. Sits beside the LED driver, in the same clock domain, with its outputs routed to ILA/VIO probes for on-board self-check.

---
 rtl/led_chk_pkg.sv | 40 ++++
 rtl/led_pattern_checker_timer.sv | 34 +++
 rtl/led_pattern_checker.sv | 191 +++++++++++++++++++
 tb/tb_led_pattern_checker.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_chk_pkg.sv
// Shared definitions for the rotating one-hot LED bus checker:
// FSM state encoding, error codes and the LED bus helper functions.
package led_chk_pkg;

    // Widest LED bus the helpers handle; narrower buses are zero-extended.
    localparam int LED_MAX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_BAD_STEP = 2'd1;
    localparam logic [1:0] ERR_PERIOD   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    // True when exactly one bit is set.
    function automatic logic is_onehot(input logic [LED_MAX_W-1:0] v);
        return (v != '0) && ((v & (v - LED_MAX_W'(1))) == '0);
    endfunction

    // Rotate the low n bits of v by one position; bits at and above n must be zero.
    // dir = 0: bit i -> bit i+1 and MSB -> bit 0; dir = 1: the opposite way.
    function automatic logic [LED_MAX_W-1:0] rotate(input logic [LED_MAX_W-1:0] v,
                                                    input int n,
                                                    input logic dir);
        logic [LED_MAX_W-1:0] mask;
        logic [LED_MAX_W-1:0] r;
        mask = (LED_MAX_W'(1) << n) - LED_MAX_W'(1);
        if (dir == 1'b0) begin
            r = ((v << 1) | (v >> (n - 1))) & mask;
        end else begin
            r = ((v >> 1) | (v << (n - 1))) & mask;
        end
        return r;
    endfunction

endpackage

// File: rtl/led_pattern_checker_timer.sv
// Saturating cycle counter measuring the time since the last LED change.
// o_interval is the step interval a change seen now would measure (count + 1,
// saturating); o_saturated is high while the count sits at all-ones.
module interval_timer #(
    parameter int NB_COUNTER = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_clear,
    output logic [NB_COUNTER-1:0] o_count,
    output logic [NB_COUNTER-1:0] o_interval,
    output logic                  o_saturated
);

    localparam logic [NB_COUNTER-1:0] CNT_MAX = '1;

    logic [NB_COUNTER-1:0] r_count;

    // Count cycles since the last clear, holding at all-ones.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (r_count != CNT_MAX) begin
            r_count <= r_count + NB_COUNTER'(1);
        end
    end

    assign o_count     = r_count;
    assign o_saturated = (r_count == CNT_MAX);
    assign o_interval  = o_saturated ? CNT_MAX : (r_count + NB_COUNTER'(1));

endmodule

// File: rtl/led_pattern_checker.sv
// Checker for a rotating one-hot LED bus: every change must be a single-step
// rotation and changes must arrive at a constant interval. Reports lock,
// the reference step period and sticky error information.
module led_pattern_checker
    import led_chk_pkg::*;
#(
    parameter int NB_LEDS    = 4,
    parameter int NB_COUNTER = 16,
    parameter int NB_ERR     = 8,
    parameter int DIR        = 0
) (
    input  logic                  clock,
    input  logic                  i_reset,
    input  logic [NB_LEDS-1:0]    i_led,
    input  logic                  i_enable,
    input  logic                  i_clear_err,
    output logic                  o_locked,
    output logic [NB_COUNTER-1:0] o_period,
    output logic                  o_error,
    output logic [1:0]            o_err_code,
    output logic [NB_ERR-1:0]     o_err_count,
    output logic [1:0]            o_dbg_state,
    output logic [NB_COUNTER-1:0] o_dbg_count
);

    // NB_LEDS must lie in 2..LED_MAX_W for the helper functions to apply.
    localparam logic [NB_COUNTER-1:0] CNT_MAX = '1;
    localparam logic [NB_ERR-1:0]     ERR_MAX = '1;
    localparam logic                  DIR_BIT = (DIR != 0);

    state_t                r_state;
    state_t                w_next_state;
    logic [NB_LEDS-1:0]    r_led_q;
    logic [NB_COUNTER-1:0] r_period;
    logic                  r_error;
    logic [1:0]            r_err_code;
    logic [NB_ERR-1:0]     r_err_count;

    logic [LED_MAX_W-1:0]  w_led_ext;
    logic [LED_MAX_W-1:0]  w_led_q_ext;
    logic                  w_change;
    logic                  w_step_ok;
    logic                  w_in_onehot;
    logic                  w_period_bad;
    logic                  w_timeout_hit;
    logic                  w_timer_clear;
    logic [NB_COUNTER-1:0] w_count;
    logic [NB_COUNTER-1:0] w_interval;
    logic                  w_saturated;
    logic                  w_err_event;
    logic [1:0]            w_err_code;
    logic                  w_load_period;
    logic [NB_ERR-1:0]     w_err_base;

    assign w_led_ext     = LED_MAX_W'(i_led);
    assign w_led_q_ext   = LED_MAX_W'(r_led_q);
    assign w_change      = (i_led != r_led_q);
    assign w_in_onehot   = is_onehot(w_led_ext);
    assign w_step_ok     = is_onehot(w_led_q_ext) &&
                           (w_led_ext == rotate(w_led_q_ext, NB_LEDS, DIR_BIT));
    assign w_period_bad  = (w_interval != r_period);
    // The edge on which the count would climb to all-ones without a change.
    assign w_timeout_hit = !w_change && !w_saturated && (w_interval == CNT_MAX);
    // Any error restarts interval measurement, as does every change.
    assign w_timer_clear = w_change || w_err_event;

    interval_timer #(
        .NB_COUNTER (NB_COUNTER)
    ) u_timer (
        .i_clock     (clock),
        .i_reset     (i_reset),
        .i_clear     (w_timer_clear),
        .o_count     (w_count),
        .o_interval  (w_interval),
        .o_saturated (w_saturated)
    );

    // Registered copy of the bus, used to detect and classify changes.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_led_q <= '0;
        end else begin
            r_led_q <= i_led;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state: disable wins, any error in LOCKED falls back to ACQUIRE.
    always_comb begin
        w_next_state = r_state;
        if (!i_enable) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_in_onehot) w_next_state = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (w_change && w_step_ok) w_next_state = ST_LOCKED;
                end
                ST_LOCKED: begin
                    if ((w_change && (!w_step_ok || w_period_bad)) || w_timeout_hit)
                        w_next_state = ST_ACQUIRE;
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: error events (BAD_STEP before PERIOD) and period reload.
    always_comb begin
        w_err_event   = 1'b0;
        w_err_code    = ERR_NONE;
        w_load_period = 1'b0;
        if (i_enable) begin
            case (r_state)
                ST_ACQUIRE: begin
                    if (w_change) begin
                        if (w_step_ok) begin
                            w_load_period = 1'b1;
                        end else begin
                            w_err_event = 1'b1;
                            w_err_code  = ERR_BAD_STEP;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_change) begin
                        if (!w_step_ok) begin
                            w_err_event = 1'b1;
                            w_err_code  = ERR_BAD_STEP;
                        end else if (w_period_bad) begin
                            w_err_event = 1'b1;
                            w_err_code  = ERR_PERIOD;
                        end
                    end else if (w_timeout_hit) begin
                        w_err_event = 1'b1;
                        w_err_code  = ERR_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    // Reference period: reloaded only by the first valid step in ACQUIRE.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_period <= '0;
        end else if (w_load_period) begin
            r_period <= w_interval;
        end
    end

    // A clear in the same cycle as an error counts from zero, so the error survives.
    assign w_err_base = i_clear_err ? '0 : r_err_count;

    // Sticky error flag, last code and saturating error count.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_error     <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_err_count <= '0;
        end else if (w_err_event) begin
            r_error     <= 1'b1;
            r_err_code  <= w_err_code;
            r_err_count <= (w_err_base == ERR_MAX) ? ERR_MAX : (w_err_base + NB_ERR'(1));
        end else if (i_clear_err) begin
            r_error     <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_err_count <= '0;
        end
    end

    assign o_locked    = (r_state == ST_LOCKED);
    assign o_period    = r_period;
    assign o_error     = r_error;
    assign o_err_code  = r_err_code;
    assign o_err_count = r_err_count;
    assign o_dbg_state = r_state;
    assign o_dbg_count = w_count;

endmodule

// File: tb/tb_led_pattern_checker.sv
// Directed bench for led_pattern_checker (4 LEDs, 4-bit timer, 3-bit error count).
module tb_led_pattern_checker;

    localparam int NB_LEDS    = 4;
    localparam int NB_COUNTER = 4;
    localparam int NB_ERR     = 3;

    logic                  clock = 1'b0;
    logic                  i_reset;
    logic [NB_LEDS-1:0]    i_led;
    logic                  i_enable;
    logic                  i_clear_err;
    logic                  o_locked;
    logic [NB_COUNTER-1:0] o_period;
    logic                  o_error;
    logic [1:0]            o_err_code;
    logic [NB_ERR-1:0]     o_err_count;
    logic [1:0]            o_dbg_state;
    logic [NB_COUNTER-1:0] o_dbg_count;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [3:0] pat [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    int idx;

    led_pattern_checker #(
        .NB_LEDS    (NB_LEDS),
        .NB_COUNTER (NB_COUNTER),
        .NB_ERR     (NB_ERR),
        .DIR        (0)
    ) dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_led       (i_led),
        .i_enable    (i_enable),
        .i_clear_err (i_clear_err),
        .o_locked    (o_locked),
        .o_period    (o_period),
        .o_error     (o_error),
        .o_err_code  (o_err_code),
        .o_err_count (o_err_count),
        .o_dbg_state (o_dbg_state),
        .o_dbg_count (o_dbg_count)
    );

    // Clock: 10 time-unit period.
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit past the last edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        i_reset     = 1'b0;
        i_led       = 4'b1010;
        i_enable    = 1'b0;
        i_clear_err = 1'b0;

        // Reset state
        tick(5);
        check_eq("rst_locked", 32'(o_locked), 32'd0);
        check_eq("rst_period", 32'(o_period), 32'd0);
        check_eq("rst_error", 32'(o_error), 32'd0);
        check_eq("rst_code", 32'(o_err_code), 32'd0);
        check_eq("rst_count", 32'(o_err_count), 32'd0);
        check_eq("rst_state", 32'(o_dbg_state), 32'd0);
        i_reset = 1'b1;
        tick(3);
        check_eq("idle_locked", 32'(o_locked), 32'd0);
        check_eq("idle_state", 32'(o_dbg_state), 32'd0);

        // Clean lock at 10 cycles per step
        i_enable = 1'b1;
        i_led    = 4'b0001;
        tick(1);
        check_eq("acq_state", 32'(o_dbg_state), 32'd1);
        tick(9);
        check_eq("acq_not_locked", 32'(o_locked), 32'd0);
        i_led = 4'b0010;
        tick(1);
        check_eq("lock_locked", 32'(o_locked), 32'd1);
        check_eq("lock_period", 32'(o_period), 32'd10);
        check_eq("lock_state", 32'(o_dbg_state), 32'd2);
        tick(9);
        idx = 1;
        for (int s = 0; s < 20; s++) begin
            idx   = (idx + 1) % 4;
            i_led = pat[idx];
            tick(1);
            check_eq("step_locked", 32'(o_locked), 32'd1);
            tick(9);
        end
        check_eq("clean_error", 32'(o_error), 32'd0);
        check_eq("clean_count", 32'(o_err_count), 32'd0);

        // Bad step 0010 -> 1000 while locked
        i_led = 4'b1000;
        tick(1);
        check_eq("bad_error", 32'(o_error), 32'd1);
        check_eq("bad_code", 32'(o_err_code), 32'd1);
        check_eq("bad_count", 32'(o_err_count), 32'd1);
        check_eq("bad_locked", 32'(o_locked), 32'd0);
        tick(9);
        i_led = 4'b0001;
        tick(1);
        check_eq("relock_locked", 32'(o_locked), 32'd1);
        check_eq("relock_period", 32'(o_period), 32'd10);

        // Period error: one step after 11 cycles
        tick(10);
        i_led = 4'b0010;
        tick(1);
        check_eq("per_code", 32'(o_err_code), 32'd2);
        check_eq("per_count", 32'(o_err_count), 32'd2);
        check_eq("per_locked", 32'(o_locked), 32'd0);
        check_eq("per_period_held", 32'(o_period), 32'd10);
        tick(10);
        i_led = 4'b0100;
        tick(1);
        check_eq("per_reload", 32'(o_period), 32'd11);
        check_eq("per_relocked", 32'(o_locked), 32'd1);
        check_eq("per_sticky", 32'(o_error), 32'd1);

        // Plain clear while locked
        i_clear_err = 1'b1;
        tick(1);
        i_clear_err = 1'b0;
        check_eq("clr_error", 32'(o_error), 32'd0);
        check_eq("clr_code", 32'(o_err_code), 32'd0);
        check_eq("clr_count", 32'(o_err_count), 32'd0);
        check_eq("clr_locked", 32'(o_locked), 32'd1);
        tick(9);
        i_led = 4'b1000;
        tick(1);
        check_eq("p11_locked", 32'(o_locked), 32'd1);
        check_eq("p11_error", 32'(o_error), 32'd0);

        // Timeout: frozen bus, fires 15 cycles after the last change
        tick(13);
        check_eq("to_pre13_locked", 32'(o_locked), 32'd1);
        tick(1);
        check_eq("to_pre14_locked", 32'(o_locked), 32'd1);
        check_eq("to_pre14_error", 32'(o_error), 32'd0);
        tick(1);
        check_eq("to_code", 32'(o_err_code), 32'd3);
        check_eq("to_error", 32'(o_error), 32'd1);
        check_eq("to_count", 32'(o_err_count), 32'd1);
        check_eq("to_locked", 32'(o_locked), 32'd0);

        // Bad steps in ACQUIRE up to a count of 5
        i_led = 4'b0010; tick(1);
        i_led = 4'b1000; tick(1);
        i_led = 4'b0010; tick(1);
        i_led = 4'b1000; tick(1);
        check_eq("acq_bad_count5", 32'(o_err_count), 32'd5);

        // Clear and BAD_STEP on the same edge
        i_clear_err = 1'b1;
        i_led       = 4'b0010;
        tick(1);
        i_clear_err = 1'b0;
        check_eq("clrbad_count", 32'(o_err_count), 32'd1);
        check_eq("clrbad_error", 32'(o_error), 32'd1);
        check_eq("clrbad_code", 32'(o_err_code), 32'd1);

        // Error count saturation at 7
        for (int k = 1; k <= 8; k++) begin
            i_led = (k % 2 == 1) ? 4'b1000 : 4'b0010;
            tick(1);
            if (k == 5) check_eq("sat_pre_count", 32'(o_err_count), 32'd6);
        end
        check_eq("sat_count", 32'(o_err_count), 32'd7);

        // Relock at 6 cycles per step
        tick(5);
        i_led = 4'b0100;
        tick(1);
        check_eq("p6_period", 32'(o_period), 32'd6);
        check_eq("p6_locked", 32'(o_locked), 32'd1);

        // Enable low: IDLE, errors untouched, no errors raised
        i_enable = 1'b0;
        tick(1);
        check_eq("dis_locked", 32'(o_locked), 32'd0);
        check_eq("dis_state", 32'(o_dbg_state), 32'd0);
        check_eq("dis_count", 32'(o_err_count), 32'd7);
        check_eq("dis_error", 32'(o_error), 32'd1);
        check_eq("dis_period", 32'(o_period), 32'd6);
        i_led = 4'b0001;
        tick(1);
        check_eq("dis_bad_count", 32'(o_err_count), 32'd7);
        check_eq("dis_bad_state", 32'(o_dbg_state), 32'd0);

        // Re-enable and lock at 2 cycles
        i_enable = 1'b1;
        tick(1);
        check_eq("en_state", 32'(o_dbg_state), 32'd1);
        i_led = 4'b0010;
        tick(1);
        check_eq("p2_locked", 32'(o_locked), 32'd1);
        check_eq("p2_period", 32'(o_period), 32'd2);

        // Asynchronous reset mid-LOCKED, away from a clock edge
        #2;
        i_reset = 1'b0;
        #1;
        check_eq("arst_locked", 32'(o_locked), 32'd0);
        check_eq("arst_period", 32'(o_period), 32'd0);
        check_eq("arst_error", 32'(o_error), 32'd0);
        check_eq("arst_code", 32'(o_err_code), 32'd0);
        check_eq("arst_count", 32'(o_err_count), 32'd0);
        check_eq("arst_state", 32'(o_dbg_state), 32'd0);
        tick(2);
        i_reset = 1'b1;
        tick(1);
        check_eq("post_arst_state", 32'(o_dbg_state), 32'd1);
        check_eq("post_arst_locked", 32'(o_locked), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
